wb_commit_queue: RTL and testbench
==================================

# wb_commit_queue

In-order dual-lane writeback queue for the 2-way superscalar core, sitting between the two execution/memory lanes and the register file's two write ports. It buffers issue-pair results, resolves same-pair write-after-write (WAW) conflicts and x0 writes, and drains one pair per cycle onto the write ports. The write-port outputs connect directly to the register file's write-port inputs.

## Interface
- DEPTH, 4, queue depth in issue pairs; must be a power of 2 and at least 2.
- XLEN, 64, data width.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue pair presented.
- in_ready  out  1  queue can accept a pair.
- in_wen0 / in_wen1  in  1  lane 0 / lane 1 write request.
- in_rd0 / in_rd1  in  5  destination register of lane 0 / lane 1.
- in_data0 / in_data1  in  XLEN  result of lane 0 / lane 1.
- drain_en  in  1  writeback permitted this cycle.
- Wen1 / Wen2  out  1  register-file write enable, lane 0 / lane 1.
- Rd_addr1 / Rd_addr2  out  5  write address.
- write_data1 / write_data2  out  XLEN  write data.
- count  out  $clog2(DEPTH)+1  number of occupied pairs.
- fwd_addr  in  4x5  forwarding query addresses, one per register-file read port (WB_FWD_EN only).
- fwd_hit  out  4  query matched a pending write (WB_FWD_EN only).
- fwd_data  out  4xXLEN  forwarded value (WB_FWD_EN only).

## Operation
- Enqueue when in_valid && in_ready. The pair is canonicalized before it is stored:
  - A lane with rd==0 has its wen cleared.
  - If in_wen0 && in_wen1 && in_rd0==in_rd1, lane 0's wen is cleared. Lane 1 is younger, so it wins.
- A pair with both wen clear is still enqueued. It occupies one drain slot and produces no writes.
- in_ready = (count < DEPTH) && !rst. There is no same-cycle pass-through when the queue is full.
- Pop when drain_en && count != 0. On the pop edge the output register loads the head pair: Wen1/Rd_addr1/write_data1 from lane 0, Wen2/Rd_addr2/write_data2 from lane 1.
- On a cycle without a pop, Wen1 and Wen2 go to 0. Addresses and data hold their previous values.
- After canonicalization, Wen1 && Wen2 with Rd_addr1==Rd_addr2 never occurs.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is tracked separately to distinguish full from empty.

## Timing
- Reset values: count=0, pointers=0, Wen1=Wen2=0, Rd_addr1=Rd_addr2=0, write_data1=write_data2=0, in_ready=0 while rst is high.
- Latency: a pair accepted at edge E into an empty queue, with drain_en high, pops at edge E+1. Its Wen outputs are high for the single cycle between E+1 and E+2.
- Sustained throughput: one pair per cycle with drain_en held high.
- drain_en low: the queue fills, and in_ready drops in the cycle after count reaches DEPTH.
- Reset mid-operation: all queued pairs are discarded and no write is emitted on the reset edge or the edge after it.

## Configuration
- WB_FWD_EN defined:
  - Four combinational lookups search all queued pairs plus the output register. The youngest match wins; within a pair, lane 1 beats lane 0.
  - Only entries with wen set match, and fwd_addr==0 never hits.
  - When a query misses, fwd_hit=0 and fwd_data=0.
- WB_FWD_EN undefined: the fwd_* ports and all comparators are absent. Queue behaviour is identical in both builds.

## Structure
- Shared package wb_pkg holds:
  - XLEN.
  - REG_ZERO (5'd0).
  - wb_pair_t struct {wen0, rd0, data0, wen1, rd1, data1}.
- The queue storage is an array of wb_pair_t.
- One sub-module, wb_fwd_lookup, is instantiated four times under WB_FWD_EN. It takes the entry array, the head pointer, count and one query address, and returns hit and data.

## Test plan
- Single pair: wen0/rd0=5/data0=0x11 and wen1/rd1=6/data1=0x22 into an empty queue with drain_en=1 → one cycle later Wen1=1/Rd_addr1=5/data 0x11 and Wen2=1/Rd_addr2=6/data 0x22, both for exactly one cycle.
- WAW in one pair: rd0=rd1=9, data 0xA and 0xB → Wen1=0, Wen2=1, Rd_addr2=9, write_data2=0xB.
- x0 drop: rd0=0 with wen0=1, and wen1=0 → pair drains with Wen1=Wen2=0; count returns to 0.
- Backpressure: drain_en=0 with 5 pairs offered back-to-back → 4 accepted, in_ready=0, count=4. Raise drain_en → pairs emerge in order over 4 cycles, and the 5th pair is accepted the cycle after the first pop.
- Reset mid-operation: with count=3, rst high for one cycle → count=0, Wen outputs stay 0, in_ready=1 in the cycle after rst falls.
- WB_FWD_EN: queue holds rd 7=0x1 (older) then rd 7=0x2 (younger), and fwd_addr[2]=7 → fwd_hit[2]=1, fwd_data[2]=0x2. A query of 0 → hit=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the dual-lane writeback queue: data width, the x0 register
// index, the issue-pair record and the pair canonicalization helper.
package wb_pkg;

  localparam int XLEN = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic            wen0;
    logic [4:0]      rd0;
    logic [XLEN-1:0] data0;
    logic            wen1;
    logic [4:0]      rd1;
    logic [XLEN-1:0] data1;
  } wb_pair_t;

  // x0 writes are dropped; on a same-pair WAW the younger lane 1 wins.
  function automatic wb_pair_t canonicalize(input wb_pair_t p);
    wb_pair_t c;
    c = p;
    if (c.rd0 == REG_ZERO) c.wen0 = 1'b0;
    if (c.rd1 == REG_ZERO) c.wen1 = 1'b0;
    if (c.wen0 && c.wen1 && (c.rd0 == c.rd1)) c.wen0 = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// One forwarding query over the output register and all queued pairs;
// the youngest pending write to the queried register wins.
module wb_fwd_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_pair_t                 entries_i [DEPTH],
  input  wb_pair_t                 out_pair_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [4:0]               addr_i,
  output logic                     hit_o,
  output logic [XLEN-1:0]          data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    if (out_pair_i.wen0 && (out_pair_i.rd0 == addr_i)) begin
      hit_o  = 1'b1;
      data_o = out_pair_i.data0;
    end
    if (out_pair_i.wen1 && (out_pair_i.rd1 == addr_i)) begin
      hit_o  = 1'b1;
      data_o = out_pair_i.data1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (i < int'(count_i)) begin
        if (entries_i[idx].wen0 && (entries_i[idx].rd0 == addr_i)) begin
          hit_o  = 1'b1;
          data_o = entries_i[idx].data0;
        end
        if (entries_i[idx].wen1 && (entries_i[idx].rd1 == addr_i)) begin
          hit_o  = 1'b1;
          data_o = entries_i[idx].data1;
        end
      end
    end
    if (addr_i == REG_ZERO) begin
      hit_o  = 1'b0;
      data_o = '0;
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order dual-lane writeback queue draining one issue pair per cycle onto
// the register-file write ports. Define WB_FWD_EN to add forwarding lookups.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wen0,
  input  logic                     in_wen1,
  input  logic [4:0]               in_rd0,
  input  logic [4:0]               in_rd1,
  input  logic [XLEN-1:0]          in_data0,
  input  logic [XLEN-1:0]          in_data1,
  input  logic                     drain_en,
  output logic                     Wen1,
  output logic                     Wen2,
  output logic [4:0]               Rd_addr1,
  output logic [4:0]               Rd_addr2,
  output logic [XLEN-1:0]          write_data1,
  output logic [XLEN-1:0]          write_data2,
`ifdef WB_FWD_EN
  input  logic [3:0][4:0]          fwd_addr,
  output logic [3:0]               fwd_hit,
  output logic [3:0][XLEN-1:0]     fwd_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_pair_t      entries_q [DEPTH];
  wb_pair_t      out_q, out_d, in_pair;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready = (count_q < CW'(DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = drain_en && (count_q != '0);
  assign in_pair  = canonicalize('{wen0: in_wen0, rd0: in_rd0, data0: in_data0,
                                   wen1: in_wen1, rd1: in_rd1, data1: in_data1});

  // Without a pop the write enables drop while address and data hold.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    out_d   = out_q;
    out_d.wen0 = 1'b0;
    out_d.wen1 = 1'b0;
    if (push) tail_d = tail_q + 1'b1;
    if (pop) begin
      head_d = head_q + 1'b1;
      out_d  = entries_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  // Storage needs no reset; occupancy is governed by count_q alone.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_q] <= in_pair;
  end

  assign Wen1        = out_q.wen0;
  assign Rd_addr1    = out_q.rd0;
  assign write_data1 = out_q.data0;
  assign Wen2        = out_q.wen1;
  assign Rd_addr2    = out_q.rd1;
  assign write_data2 = out_q.data1;
  assign count       = count_q;

`ifdef WB_FWD_EN
  for (genvar g = 0; g < 4; g++) begin : gen_fwd
    wb_fwd_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries_i  (entries_q),
      .out_pair_i (out_q),
      .head_i     (head_q),
      .count_i    (count_q),
      .addr_i     (fwd_addr[g]),
      .hit_o      (fwd_hit[g]),
      .data_o     (fwd_data[g])
    );
  end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed self-checking bench for wb_commit_queue (forwarding checks run when
// WB_FWD_EN is defined).
module tb_wb_commit_queue;
  import wb_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_wen0, in_wen1, drain_en;
  logic [4:0]      in_rd0, in_rd1, Rd_addr1, Rd_addr2;
  logic [XLEN-1:0] in_data0, in_data1, write_data1, write_data2;
  logic            Wen1, Wen2;
  logic [2:0]      count;
`ifdef WB_FWD_EN
  logic [3:0][4:0]      fwd_addr;
  logic [3:0]           fwd_hit;
  logic [3:0][XLEN-1:0] fwd_data;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  wb_commit_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wen0(in_wen0), .in_wen1(in_wen1), .in_rd0(in_rd0), .in_rd1(in_rd1),
    .in_data0(in_data0), .in_data1(in_data1), .drain_en(drain_en),
    .Wen1(Wen1), .Wen2(Wen2), .Rd_addr1(Rd_addr1), .Rd_addr2(Rd_addr2),
    .write_data1(write_data1), .write_data2(write_data2),
`ifdef WB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w0, input logic [4:0] r0,
                               input logic [63:0] d0, input logic w1,
                               input logic [4:0] r1, input logic [63:0] d1);
    in_valid = v;
    in_wen0  = w0;
    in_rd0   = r0;
    in_data0 = d0;
    in_wen1  = w1;
    in_rd1   = r1;
    in_data1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drain_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
`ifdef WB_FWD_EN
    fwd_addr = '0;
`endif
    tick();
    tick();
    checkOutput("reset count", 64'(count), 64'd0);
    checkOutput("reset Wen1", 64'(Wen1), 64'd0);
    checkOutput("reset Wen2", 64'(Wen2), 64'd0);
    checkOutput("reset Rd_addr1", 64'(Rd_addr1), 64'd0);
    checkOutput("reset Rd_addr2", 64'(Rd_addr2), 64'd0);
    checkOutput("reset write_data1", write_data1, 64'd0);
    checkOutput("reset write_data2", write_data2, 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready after reset", 64'(in_ready), 64'd1);

    // single pair: enqueue at E, pop at E+1, enables high one cycle
    drain_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("single count E", 64'(count), 64'd1);
    checkOutput("single Wen1 E", 64'(Wen1), 64'd0);
    tick();
    checkOutput("single Wen1", 64'(Wen1), 64'd1);
    checkOutput("single Rd_addr1", 64'(Rd_addr1), 64'd5);
    checkOutput("single data1", write_data1, 64'h11);
    checkOutput("single Wen2", 64'(Wen2), 64'd1);
    checkOutput("single Rd_addr2", 64'(Rd_addr2), 64'd6);
    checkOutput("single data2", write_data2, 64'h22);
    checkOutput("single count", 64'(count), 64'd0);
    tick();
    checkOutput("single Wen1 drop", 64'(Wen1), 64'd0);
    checkOutput("single Wen2 drop", 64'(Wen2), 64'd0);
    checkOutput("single Rd_addr1 hold", 64'(Rd_addr1), 64'd5);
    checkOutput("single data2 hold", write_data2, 64'h22);

    // WAW inside one pair: lane 1 wins
    applyStimulus(1'b1, 1'b1, 5'd9, 64'hA, 1'b1, 5'd9, 64'hB);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    tick();
    checkOutput("waw Wen1", 64'(Wen1), 64'd0);
    checkOutput("waw Wen2", 64'(Wen2), 64'd1);
    checkOutput("waw Rd_addr2", 64'(Rd_addr2), 64'd9);
    checkOutput("waw data2", write_data2, 64'hB);
    tick();

    // x0 write dropped, pair still occupies a slot
    applyStimulus(1'b1, 1'b1, 5'd0, 64'h77, 1'b0, 5'd3, 64'h88);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("x0 count in", 64'(count), 64'd1);
    tick();
    checkOutput("x0 Wen1", 64'(Wen1), 64'd0);
    checkOutput("x0 Wen2", 64'(Wen2), 64'd0);
    checkOutput("x0 count out", 64'(count), 64'd0);

    // backpressure: five pairs offered with drain disabled
    drain_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(k + 1), 64'h100 + 64'(k), 1'b1, 5'(k + 11), 64'h200 + 64'(k));
      #1;
      checkOutput($sformatf("bp ready %0d", k), 64'(in_ready), (k < 4) ? 64'd1 : 64'd0);
      tick();
    end
    checkOutput("bp count full", 64'(count), 64'd4);
    checkOutput("bp ready full", 64'(in_ready), 64'd0);
    drain_en = 1'b1;
    tick();
    checkOutput("bp pop0 Rd_addr1", 64'(Rd_addr1), 64'd1);
    checkOutput("bp pop0 data1", write_data1, 64'h100);
    checkOutput("bp pop0 count", 64'(count), 64'd3);
    checkOutput("bp pop0 ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("bp pop1 Rd_addr1", 64'(Rd_addr1), 64'd2);
    checkOutput("bp pop1 count", 64'(count), 64'd3);
    for (int j = 2; j < 5; j++) begin
      tick();
      checkOutput($sformatf("bp pop%0d Wen1", j), 64'(Wen1), 64'd1);
      checkOutput($sformatf("bp pop%0d Rd_addr1", j), 64'(Rd_addr1), 64'(j + 1));
      checkOutput($sformatf("bp pop%0d Rd_addr2", j), 64'(Rd_addr2), 64'(j + 11));
      checkOutput($sformatf("bp pop%0d data2", j), write_data2, 64'h200 + 64'(j));
      checkOutput($sformatf("bp pop%0d count", j), 64'(count), 64'(4 - j));
    end
    tick();
    checkOutput("bp idle Wen1", 64'(Wen1), 64'd0);

    // reset with three pairs queued
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(k + 20), 64'h300 + 64'(k), 1'b0, 5'd0, 64'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("rst pre count", 64'(count), 64'd3);
    rst = 1'b1;
    drain_en = 1'b1;
    tick();
    checkOutput("rst count", 64'(count), 64'd0);
    checkOutput("rst Wen1", 64'(Wen1), 64'd0);
    checkOutput("rst ready high", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst ready after", 64'(in_ready), 64'd1);
    tick();
    checkOutput("rst post Wen1", 64'(Wen1), 64'd0);
    checkOutput("rst post Wen2", 64'(Wen2), 64'd0);
    checkOutput("rst post count", 64'(count), 64'd0);

`ifdef WB_FWD_EN
    // forwarding: youngest pending write to r7 wins, x0 never hits
    drain_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h1, 1'b0, 5'd0, 64'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 64'h2, 1'b0, 5'd0, 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    fwd_addr[0] = 5'd0;
    fwd_addr[1] = 5'd3;
    fwd_addr[2] = 5'd7;
    fwd_addr[3] = 5'd7;
    #1;
    checkOutput("fwd hit2", 64'(fwd_hit[2]), 64'd1);
    checkOutput("fwd data2", fwd_data[2], 64'h2);
    checkOutput("fwd hit0 x0", 64'(fwd_hit[0]), 64'd0);
    checkOutput("fwd data0 x0", fwd_data[0], 64'd0);
    checkOutput("fwd hit1 miss", 64'(fwd_hit[1]), 64'd0);
    drain_en = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("fwd drained hit3", 64'(fwd_hit[3]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
